// File: rtl/fracnet_udiv_seq.sv
// fracnet_udiv_seq
// Sequential unsigned restoring divider, one quotient bit per cycle (no DSP).
// Inverse of the FracNet 8x11 multiplier; also used for rescaling/normalising.
//
// Ports
//   ap_clk       clock, rising edge
//   ap_rst_n     asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     block idle, can accept an operand pair
//   dividend     unsigned dividend  [DIVIDEND_WIDTH-1:0]
//   divisor      unsigned divisor   [DIVISOR_WIDTH-1:0]
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts result
//   quotient     dividend / divisor (all ones on divide-by-zero)
//   remainder    dividend % divisor (dividend LSBs on divide-by-zero)
//   div_by_zero  result came from divisor == 0
module fracnet_udiv_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 19,
  parameter int unsigned DIVISOR_WIDTH  = 11
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned SW = DIVISOR_WIDTH;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB;
  // after DW steps the register holds the complete quotient.
  logic [DW-1:0] wq;
  logic [SW-1:0] dsr;
  logic [SW-1:0] r;

  logic [SW:0]   t;
  logic          tge;
  logic [SW-1:0] r_nx;
  logic [DW-1:0] wq_nx;

  // One restoring step. t carries the extra bit needed for the compare;
  // the difference always fits SW bits because r < divisor before the step.
  always_comb begin
    t     = {r, wq[DW-1]};
    tge   = (t >= {1'b0, dsr});
    r_nx  = tge ? (t[SW-1:0] - dsr) : t[SW-1:0];
    wq_nx = {wq[DW-2:0], tge};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt         <= '0;
      wq          <= '0;
      dsr         <= '0;
      r           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wq  <= dividend;
            dsr <= divisor;
            r   <= '0;
            cnt <= CW'(DW - 1);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[SW-1:0];
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          wq  <= wq_nx;
          r   <= r_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient    <= wq_nx;
            remainder   <= r_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fracnet_udiv_seq.sv
module tb_fracnet_udiv_seq;

  localparam int unsigned DW = 19;
  localparam int unsigned SW = 11;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  int checks   = 0;
  int failures = 0;

  fracnet_udiv_seq #(
    .DIVIDEND_WIDTH(DW),
    .DIVISOR_WIDTH (SW)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, all-ones / dividend LSBs on zero divisor.
  task automatic model(input logic [DW-1:0] a, input logic [SW-1:0] b,
                       output logic [DW-1:0] q, output logic [SW-1:0] r,
                       output logic z);
    logic [DW-1:0] lsb;
    if (b == 0) begin
      q   = {DW{1'b1}};
      lsb = a;
      r   = lsb[SW-1:0];
      z   = 1'b1;
    end else begin
      q = DW'(int'(a) / int'(b));
      r = SW'(int'(a) % int'(b));
      z = 1'b0;
    end
  endtask

  // Present a pair, return #1 after the accept edge with garbage on the inputs.
  task automatic start(input logic [DW-1:0] a, input logic [SW-1:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = SW'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    if (!out_valid) chk("result_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic directed(input string tag, input logic [DW-1:0] a, input logic [SW-1:0] b,
                          input int exp_lat, input logic [DW-1:0] eq,
                          input logic [SW-1:0] er, input logic ez);
    int lat;
    start(a, b);
    wait_valid(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
    chk({tag, "_remainder"}, 64'(remainder), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    release_result(tag);
  endtask

  initial begin
    int            lat;
    int            accepted;
    int            results;
    bit            bad;
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    logic [DW-1:0] eq;
    logic [SW-1:0] er;
    logic          ez;

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    directed("invmul", 19'd300000, 11'd1500, 20, 19'd200, 11'd0, 1'b0);
    directed("maxop", 19'd524287, 11'd2047, 20, 19'd256, 11'd255, 1'b0);
    directed("d1000_7", 19'd1000, 11'd7, 20, 19'd142, 11'd6, 1'b0);
    directed("divzero", 19'd12345, 11'd0, 1, 19'h7FFFF, 11'd57, 1'b1);
    directed("div1", 19'd77777, 11'd1, 20, 19'd77777, 11'd0, 1'b0);
    directed("zero_dvd", 19'd0, 11'd3, 20, 19'd0, 11'd0, 1'b0);

    // Backpressure: result must hold while out_ready stays low.
    start(19'd5, 11'd9);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd20);
    for (int i = 0; i < 5; i++) begin
      chk("bp_quotient", 64'(quotient), 64'd0);
      chk("bp_remainder", 64'(remainder), 64'd5);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge ap_clk); #1;
    end
    release_result("bp");

    // Asynchronous reset in the middle of a calculation.
    start(19'd1000, 11'd7);
    repeat (9) @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_quotient", 64'(quotient), 64'd0);
    chk("arst_remainder", 64'(remainder), 64'd0);
    chk("arst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(posedge ap_clk); #1;
      if (out_valid) bad = 1'b1;
    end
    chk("arst_no_result", 64'(bad), 64'd0);
    directed("post_rst", 19'd1000, 11'd7, 20, 19'd142, 11'd6, 1'b0);

    // Randomised back-to-back traffic with random producer gaps and
    // random out_ready (also asserted before the result is ready).
    accepted = 0;
    results  = 0;
    for (int n = 0; n < 1000; n++) begin
      int  sel;
      int  cyc;
      bit  seen;
      bit  hs;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1:       b = 11'd1;
        2:       b = SW'($urandom_range(2, 15));
        default: b = SW'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) a = DW'($urandom_range(0, 40));
      else                           a = DW'($urandom);
      model(a, b, eq, er, ez);
      repeat ($urandom_range(0, 3)) begin
        @(posedge ap_clk); #1;
      end
      start(a, b);
      accepted++;
      lat  = 1;
      seen = 1'b0;
      cyc  = 0;
      forever begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          results++;
          chk("rnd_latency", 64'(lat), (b == 0) ? 64'd1 : 64'd20);
          chk("rnd_quotient", 64'(quotient), 64'(eq));
          chk("rnd_remainder", 64'(remainder), 64'(er));
          chk("rnd_dbz", 64'(div_by_zero), 64'(ez));
          if (b != 0)
            chk("rnd_invariant", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
        end
        out_ready = 1'($urandom_range(0, 1));
        hs = out_valid && out_ready;
        @(posedge ap_clk); #1;
        if (!seen) lat++;
        cyc++;
        if (hs) break;
        if (cyc > 200) begin
          chk("rnd_timeout", 64'(cyc), 64'd0);
          break;
        end
      end
      out_ready = 1'b0;
      chk("rnd_no_dup", 64'(out_valid), 64'd0);
    end
    chk("rnd_result_count", 64'(results), 64'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
